pipe_elastic_reg: RTL and testbench
===================================

PIPE_ELASTIC_REG -- requirements
Module: pipe_elastic_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of one packed stage payload (any if_id/id_ex/ex_mem/mem_wb struct).
REQ-002 The block SHALL have parameter DEPTH, default 2: number of buffer entries, legal values 1 or 2; any other value is an elaboration error.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream stage presents a payload.
REQ-006 The block SHALL have port in_data, input, DATA_W bits: the upstream payload.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-009 The block SHALL have port out_data, output, DATA_W bits: the head entry payload.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the head.
REQ-011 The block SHALL have port flush, input, 1 bit: discard all entries (branch/jump redirect).
REQ-012 The block SHALL have port occupancy, output, 2 bits: current entry count, 0..DEPTH.
REQ-013 The block SHALL have port flush_cnt, output, 16 bits: running total of valid entries discarded by flush.

Function
REQ-014 Push SHALL occur on a rising edge where in_valid & in_ready; pop SHALL occur on a rising edge where out_valid & out_ready.
REQ-015 Entries SHALL leave in FIFO order; out_data SHALL be the oldest stored entry.
REQ-016 out_valid SHALL be (occupancy != 0) & !flush.
REQ-017 out_data SHALL be all-zero whenever occupancy == 0, giving a NOP bubble.
REQ-018 With DEPTH=1, in_ready SHALL be !flush & (occupancy==0 | out_ready), a combinational pass-through of backpressure.
REQ-019 With DEPTH=2, in_ready SHALL be !flush & (occupancy < 2), with no combinational dependence on out_ready (skid mode).
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged and SHALL sustain one transfer per cycle.
REQ-021 Latency SHALL be 1 cycle: a payload pushed at edge N is on out_data/out_valid after edge N when the buffer was empty.
REQ-022 Occupancy SHALL never exceed DEPTH or go below 0; with DEPTH=2 a full buffer SHALL deassert in_ready, and in_valid then SHALL be held by upstream.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Flush SHALL take priority over push and pop; at the edge with flush=1, occupancy SHALL go to 0, pointers SHALL go to 0, and no push or pop SHALL occur.
REQ-025 At a flush edge, flush_cnt SHALL add the pre-flush occupancy and SHALL saturate at 0xFFFF.
REQ-026 With flush held for several cycles, the buffer SHALL stay empty and flush_cnt SHALL add 0 on the later cycles.
REQ-027 Deasserted in_valid SHALL insert no entry; bubbles SHALL not be stored.

Reset
REQ-028 On rst_n=0 the block SHALL asynchronously set occupancy=0, pointers=0, flush_cnt=0, and all storage=0.
REQ-029 During reset the block SHALL drive out_valid=0, out_data=0, and in_ready=0.
REQ-030 After rst_n rises, in_ready SHALL be 1 from the first edge; a reset asserted mid-transfer SHALL discard all entries without incrementing flush_cnt.

Verification
REQ-031 Streaming, DEPTH=2: push 0x11,0x22,0x33 with out_ready=1 on consecutive cycles -> out_data 0x11,0x22,0x33 on consecutive cycles, occupancy stays 1, in_ready stays 1.
REQ-032 Backpressure, DEPTH=2: out_ready=0, push 0xA, 0xB -> occupancy=2, in_ready=0, 0xC held; then out_ready=1 -> pops 0xA,0xB,0xC in order with no loss or duplication.
REQ-033 DEPTH=1 stall: occupancy=1, out_ready=0, in_valid=1 -> in_ready=0; with out_ready=1 in the same cycle -> in_ready=1, and the new data replaces the head after the edge.
REQ-034 Flush: occupancy=2 with flush=1 and in_valid=1 on the same edge -> occupancy=0, input dropped, out_valid=0, flush_cnt += 2; a later flush on an empty buffer -> flush_cnt unchanged.
REQ-035 Saturation: preload flush_cnt to 0xFFFE, then flush with occupancy=2 -> flush_cnt=0xFFFF.
REQ-036 Async reset: drop rst_n between clock edges with occupancy=2 -> out_valid=0, occupancy=0, out_data=0 immediately, flush_cnt=0.

Source files
------------

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register between two processor stages: a 1- or 2-entry FIFO
// with valid/ready handshake, redirect flush and a saturating discard counter.
module pipe_elastic_reg #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [15:0]       flush_cnt
);

    generate
        if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
            $error("pipe_elastic_reg: DEPTH must be 1 or 2");
        end
    endgenerate

    localparam logic [1:0] DEPTH_L = 2'(DEPTH);

    // Two slots are always declared; with DEPTH=1 the pointers stay at 0 and
    // slot 1 is never written.
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic [16:0]       fsum;
    logic              push, pop;

    always_comb begin
        out_valid = (occ_q != 2'd0) & ~flush;
        out_data  = (occ_q == 2'd0) ? '0 : mem_q[rd_ptr_q];
        // rst_n gating holds in_ready low while reset is asserted.
        if (DEPTH == 1) begin
            in_ready = rst_n & ~flush & ((occ_q == 2'd0) | out_ready);
        end else begin
            in_ready = rst_n & ~flush & (occ_q < DEPTH_L);
        end
    end

    always_comb begin
        push     = in_valid & in_ready;
        pop      = out_valid & out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        fcnt_d   = fcnt_q;
        fsum     = {1'b0, fcnt_q} + {15'd0, occ_q};
        if (flush) begin
            occ_d    = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            fcnt_d   = fsum[16] ? 16'hFFFF : fsum[15:0];
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = (DEPTH == 1) ? 1'b0 : ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = (DEPTH == 1) ? 1'b0 : ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            fcnt_q   <= 16'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign occupancy = occ_q;
    assign flush_cnt = fcnt_q;

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed bench for pipe_elastic_reg: one DEPTH=2 and one DEPTH=1 instance
// sharing clock and reset, expected values written out by hand.
module tb_pipe_elastic_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv2 = 0, or2 = 0, fl2 = 0;
    logic [7:0]  id2 = '0;
    logic        ir2, ov2;
    logic [7:0]  od2;
    logic [1:0]  oc2;
    logic [15:0] fc2;

    logic        iv1 = 0, or1 = 0, fl1 = 0;
    logic [7:0]  id1 = '0;
    logic        ir1, ov1;
    logic [7:0]  od1;
    logic [1:0]  oc1;
    logic [15:0] fc1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_elastic_reg #(.DATA_W(8), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_ready(or2), .flush(fl2),
        .occupancy(oc2), .flush_cnt(fc2)
    );

    pipe_elastic_reg #(.DATA_W(8), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(or1), .flush(fl1),
        .occupancy(oc1), .flush_cnt(fc1)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] sv [3];
        sv[0] = 8'h11; sv[1] = 8'h22; sv[2] = 8'h33;

        // Reset state
        #3;
        chk_val("rst_out_valid", 32'(ov2), 32'd0);
        chk_val("rst_out_data", 32'(od2), 32'd0);
        chk_val("rst_in_ready", 32'(ir2), 32'd0);
        chk_val("rst_occ", 32'(oc2), 32'd0);
        chk_val("rst_fcnt", 32'(fc2), 32'd0);
        chk_val("rst_in_ready_d1", 32'(ir1), 32'd0);
        #9 rst_n = 1'b1;
        tick();
        chk_val("post_rst_in_ready", 32'(ir2), 32'd1);
        chk_val("post_rst_in_ready_d1", 32'(ir1), 32'd1);

        // Streaming through DEPTH=2
        or2 = 1; iv2 = 1;
        for (int i = 0; i < 3; i++) begin
            id2 = sv[i];
            tick();
            chk_val($sformatf("stream_data%0d", i), 32'(od2), 32'(sv[i]));
            chk_val($sformatf("stream_occ%0d", i), 32'(oc2), 32'd1);
            chk_val($sformatf("stream_rdy%0d", i), 32'(ir2), 32'd1);
        end
        iv2 = 0;
        tick();
        chk_val("stream_drain_occ", 32'(oc2), 32'd0);
        chk_val("stream_bubble_data", 32'(od2), 32'd0);
        chk_val("stream_bubble_valid", 32'(ov2), 32'd0);

        // Backpressure fills the skid buffer
        or2 = 0; iv2 = 1; id2 = 8'h0A;
        tick();
        id2 = 8'h0B;
        tick();
        id2 = 8'h0C;
        #1;
        chk_val("bp_occ_full", 32'(oc2), 32'd2);
        chk_val("bp_in_ready", 32'(ir2), 32'd0);
        chk_val("bp_head_a", 32'(od2), 32'h0A);
        tick();
        chk_val("bp_hold_occ", 32'(oc2), 32'd2);
        or2 = 1;
        tick();
        chk_val("bp_pop_b", 32'(od2), 32'h0B);
        chk_val("bp_occ_after_a", 32'(oc2), 32'd1);
        tick();
        chk_val("bp_pop_c", 32'(od2), 32'h0C);
        chk_val("bp_occ_after_b", 32'(oc2), 32'd1);
        iv2 = 0;
        tick();
        chk_val("bp_drained", 32'(oc2), 32'd0);

        // Flush of a full buffer with a simultaneous push
        or2 = 0; iv2 = 1; id2 = 8'h01;
        tick();
        id2 = 8'h02;
        tick();
        fl2 = 1; id2 = 8'h03;
        #1;
        chk_val("fl_out_valid_comb", 32'(ov2), 32'd0);
        chk_val("fl_in_ready_comb", 32'(ir2), 32'd0);
        tick();
        fl2 = 0; iv2 = 0;
        #1;
        chk_val("fl_occ", 32'(oc2), 32'd0);
        chk_val("fl_out_valid", 32'(ov2), 32'd0);
        chk_val("fl_cnt", 32'(fc2), 32'd2);
        fl2 = 1;
        tick();
        tick();
        fl2 = 0;
        #1;
        chk_val("fl_empty_cnt", 32'(fc2), 32'd2);
        iv2 = 1; id2 = 8'h44;
        tick();
        iv2 = 0;
        #1;
        chk_val("fl_ptr_reset_head", 32'(od2), 32'h44);
        chk_val("fl_ptr_reset_occ", 32'(oc2), 32'd1);

        // Saturation of the discard counter
        iv2 = 1; id2 = 8'h55;
        tick();
        iv2 = 0;
        force u_dut2.fcnt_q = 16'hFFFE;
        #1;
        release u_dut2.fcnt_q;
        #1;
        chk_val("sat_preload", 32'(fc2), 32'hFFFE);
        fl2 = 1;
        tick();
        fl2 = 0;
        #1;
        chk_val("sat_cnt", 32'(fc2), 32'hFFFF);
        iv2 = 1; id2 = 8'h66;
        tick();
        iv2 = 0; fl2 = 1;
        tick();
        fl2 = 0;
        #1;
        chk_val("sat_hold", 32'(fc2), 32'hFFFF);

        // DEPTH=1 stall and replace
        iv1 = 1; or1 = 0; id1 = 8'h5A;
        tick();
        id1 = 8'h6B;
        #1;
        chk_val("d1_stall_rdy", 32'(ir1), 32'd0);
        tick();
        chk_val("d1_stall_head", 32'(od1), 32'h5A);
        chk_val("d1_stall_occ", 32'(oc1), 32'd1);
        or1 = 1;
        #1;
        chk_val("d1_pass_rdy", 32'(ir1), 32'd1);
        tick();
        chk_val("d1_replace_head", 32'(od1), 32'h6B);
        chk_val("d1_replace_occ", 32'(oc1), 32'd1);
        iv1 = 0;
        tick();
        chk_val("d1_drain_occ", 32'(oc1), 32'd0);
        chk_val("d1_drain_data", 32'(od1), 32'd0);
        fl1 = 1;
        #1;
        chk_val("d1_flush_rdy", 32'(ir1), 32'd0);
        fl1 = 0;

        // Async reset mid-transfer with a full buffer
        or2 = 0; iv2 = 1; id2 = 8'h77;
        tick();
        id2 = 8'h88;
        tick();
        iv2 = 0;
        #1;
        chk_val("ar_pre_occ", 32'(oc2), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_val("ar_out_valid", 32'(ov2), 32'd0);
        chk_val("ar_occ", 32'(oc2), 32'd0);
        chk_val("ar_out_data", 32'(od2), 32'd0);
        chk_val("ar_fcnt", 32'(fc2), 32'd0);
        chk_val("ar_in_ready", 32'(ir2), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk_val("ar_post_rdy", 32'(ir2), 32'd1);
        chk_val("ar_post_fcnt", 32'(fc2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
